// File: rtl/arith_pkg.sv
// Shared definitions for the serial add/subtract family: default sizing and
// the state encoding used by the slice-sequencing controllers.
package arith_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_SLICE = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sub_slice_4.sv
// Combinational SLICE-bit subtract: diff = a - b - b_in, computed as
// a + ~b + ~b_in so the adder carry-out is the inverted borrow.
module sub_slice_4
   import arith_pkg::*;
#(
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             b_in,
   output logic [SLICE-1:0] diff,
   output logic             b_out
);

   logic [SLICE-1:0] w_b_inv;
   logic             w_bin_inv;
   logic [SLICE:0]   w_sum;

   assign w_b_inv   = ~b;
   assign w_bin_inv = ~b_in;
   assign w_sum     = {1'b0, a} + {1'b0, w_b_inv} + {{SLICE{1'b0}}, w_bin_inv};

   assign diff  = w_sum[SLICE-1:0];
   assign b_out = ~w_sum[SLICE];

endmodule

// File: rtl/sub_serial_16.sv
// Multi-cycle subtractor: a - b - b_in evaluated one slice per clock, LSB
// slice first, with the borrow carried between slices in a flop.
module sub_serial_16
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             ovf
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   generate
      if ((WIDTH % SLICE) != 0) begin : g_bad_size
         $error("WIDTH must be a multiple of SLICE");
      end
   endgenerate

   state_e             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_borrow;
   logic [WIDTH-1:0]   r_diff;
   logic               r_b_out;
   logic               r_ovf;
   logic               r_done;
   logic               r_busy;

   logic [BASE_W-1:0]  w_base;
   logic [SLICE-1:0]   w_a_slice;
   logic [SLICE-1:0]   w_b_slice;
   logic [SLICE-1:0]   w_slice_diff;
   logic               w_slice_bout;
   logic               w_last;
   logic               w_ovf;

   // Bit offset of the slice currently being processed.
   assign w_base    = BASE_W'(r_idx * SLICE);
   assign w_a_slice = r_a[w_base +: SLICE];
   assign w_b_slice = r_b[w_base +: SLICE];
   assign w_last    = (r_idx == IDX_W'(NSLICE - 1));

   // On the last slice the slice MSB is the result sign bit.
   assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                  (w_slice_diff[SLICE-1] != r_a[WIDTH-1]);

   sub_slice_4 #(
      .SLICE (SLICE)
   ) u_slice (
      .a     (w_a_slice),
      .b     (w_b_slice),
      .b_in  (r_borrow),
      .diff  (w_slice_diff),
      .b_out (w_slice_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_diff   <= '0;
         r_b_out  <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= b_in;
                  r_idx    <= '0;
                  r_diff   <= '0;
                  r_b_out  <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_diff[w_base +: SLICE] <= w_slice_diff;
               r_borrow                <= w_slice_bout;
               if (w_last) begin
                  r_b_out <= w_slice_bout;
                  r_ovf   <= w_ovf;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign diff  = r_diff;
   assign b_out = r_b_out;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_sub_serial_16.sv
// Scoreboard bench for sub_serial_16: expected {ovf, b_out, diff} is queued at
// drive time and compared whenever the DUT pulses done.
module tb_sub_serial_16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        b_in;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        b_out;
   logic        ovf;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int n_done = 0;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;

   logic [17:0] exp_q[$];

   sub_serial_16 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
   endtask

   // Reference: 17-bit unsigned difference gives borrow; signed range gives overflow.
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mbin);
      logic [16:0] r;
      int          sa;
      int          sb;
      int          s;
      logic        o;
      r  = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
      sa = $signed(ma);
      sb = $signed(mb);
      s  = sa - sb - (mbin ? 1 : 0);
      o  = (s > 32767) || (s < -32768);
      return {o, r[16], r[15:0]};
   endfunction

   // Scoreboard consumer.
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("diff",  32'(diff),  32'(e[15:0]));
               check("b_out", 32'(b_out), 32'(e[16]));
               check("ovf",   32'(ovf),   32'(e[17]));
            end
         end
      end
   end

   task automatic scramble();
      a    = 16'($urandom);
      b    = 16'($urandom);
      b_in = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   // One operation; operands are scrambled every cycle after acceptance.
   task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic obin,
                         output int lat);
      wait_idle();
      a     = oa;
      b     = ob;
      b_in  = obin;
      start = 1'b1;
      exp_q.push_back(model(oa, ob, obin));
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      check("busy_on_accept", 32'(busy), 32'd1);
      check("clear_on_accept", {diff, 14'd0, b_out, ovf}, 32'd0);
      scramble();
      while (!done && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         scramble();
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      int lat;
      int base;
      logic [17:0] e;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      b_in  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_diff",  32'(diff),  32'd0);
      check("rst_b_out", 32'(b_out), 32'd0);
      check("rst_ovf",   32'(ovf),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic op, latency, pulse width and hold through IDLE.
      run_op(16'h1234, 16'h0234, 1'b0, lat);
      check("latency", 32'(lat), 32'd5);
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("hold_diff", 32'(diff), 32'h1000);
      check("hold_b_out", 32'(b_out), 32'd0);

      run_op(16'h0000, 16'h0001, 1'b0, lat);
      check("latency2", 32'(lat), 32'd5);
      run_op(16'h8000, 16'h0001, 1'b0, lat);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
      run_op(16'h0005, 16'h0005, 1'b1, lat);
      run_op(16'h0000, 16'h0000, 1'b0, lat);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
      @(negedge clk);

      // Continuous start with fresh operands: only edges 0 and 6 accept.
      wait_idle();
      base = n_done;
      for (int j = 0; j < 12; j++) begin
         scramble();
         start = 1'b1;
         if (j == 0 || j == 6) exp_q.push_back(model(a, b, b_in));
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("done_count", 32'(n_done - base), 32'd2);
      check("accept_interval", 32'(last_done_cyc - prev_done_cyc), 32'd6);

      // Reset during the second RUN cycle aborts the operation.
      wait_idle();
      a     = 16'hFFFF;
      b     = 16'h0000;
      b_in  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("partial_diff", 32'(diff), 32'h000F);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy",  32'(busy),  32'd0);
      check("abort_diff",  32'(diff),  32'd0);
      check("abort_done",  32'(done),  32'd0);
      check("abort_b_out", 32'(b_out), 32'd0);
      rst = 1'b0;
      base = n_done;
      repeat (8) @(negedge clk);
      check("no_done_after_abort", 32'(n_done - base), 32'd0);

      // Random vectors against the reference model.
      for (int i = 0; i < 1000; i++) begin
         e = 18'($urandom);
         run_op(e[15:0], 16'($urandom), e[16], lat);
      end
      @(negedge clk);
      @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
